// File: rtl/pipe_ctrl_pkg.sv
// Shared stall codes, sequencer states and widths for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int ADDR_W  = 32;
    localparam int STALL_W = 6;

    // bit 0 holds the PC, bits 1..5 freeze IF, ID, EX, MEM, WB in that order
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic {
        CTRL_IDLE  = 1'b0,
        CTRL_MULTI = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencer.
interface pipe_ctrl_if #(
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
);
    import pipe_ctrl_pkg::*;

    logic                stallreq_id;
    logic                stallreq_ex;
    logic                mc_start;
    logic [CNT_W-1:0]    mc_cycles;
    logic                flush_req;
    logic [ADDR_W-1:0]   flush_pc;

    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [ADDR_W-1:0]   new_pc;
    logic                mc_busy;
    logic                mc_last;
    logic [PERF_W-1:0]   stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
        input  stall, flush, new_pc, mc_busy, mc_last, stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, mc_start, mc_cycles, flush_req, flush_pc,
        output stall, flush, new_pc, mc_busy, mc_last, stall_cnt
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; reusable for perf counters.
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [PERF_W-1:0] cnt
);

    logic [PERF_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1))
            cnt_d = cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests, sequences multi-cycle EX ops,
// issues flush/redirect and counts PC-hold cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    ctrl_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_lat_q, n_lat_d;

    logic               mc_stall;
    logic               mc_last;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_lat_d  = n_lat_q;
        mc_stall = 1'b0;
        mc_last  = 1'b0;
        flush    = 1'b0;
        new_pc   = '0;

        if (bus.flush_req) begin
            // aborting an in-flight op must not produce its mc_last
            flush   = 1'b1;
            new_pc  = bus.flush_pc;
            state_d = CTRL_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                CTRL_IDLE: begin
                    if (bus.mc_start) begin
                        if (bus.mc_cycles >= CNT_W'(2)) begin
                            mc_stall = 1'b1;
                            n_lat_d  = bus.mc_cycles;
                            cnt_d    = CNT_W'(1);
                            state_d  = CTRL_MULTI;
                        end else begin
                            mc_last = 1'b1;
                        end
                    end
                end
                CTRL_MULTI: begin
                    if (cnt_q == n_lat_q - CNT_W'(1)) begin
                        mc_last = 1'b1;
                        state_d = CTRL_IDLE;
                        cnt_d   = '0;
                    end else begin
                        mc_stall = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = CTRL_IDLE;
            endcase
        end

        if (bus.flush_req)                       stall = STALL_NONE;
        else if (mc_stall || bus.stallreq_ex)    stall = STALL_EX;
        else if (bus.stallreq_id)                stall = STALL_ID;
        else                                     stall = STALL_NONE;

        // reset masks every output regardless of what the inputs are doing
        if (rst) begin
            stall   = STALL_NONE;
            flush   = 1'b0;
            new_pc  = '0;
            mc_last = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_IDLE;
            cnt_q   <= '0;
            n_lat_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_lat_q <= n_lat_d;
        end
    end

    assign bus.stall   = stall;
    assign bus.flush   = flush;
    assign bus.new_pc  = new_pc;
    assign bus.mc_last = mc_last;
    assign bus.mc_busy = (state_q == CTRL_MULTI) && !rst;

    sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall[0]),
        .cnt (bus.stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, multi-cycle sequencing, priority,
// abort, reset mid-op and counter saturation on a narrow build.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(3), .PERF_W(32)) b ();
    pipe_ctrl_if #(.CNT_W(3), .PERF_W(4))  s ();

    pipe_ctrl #(.CNT_W(3), .PERF_W(32)) dut   (.clk(clk), .rst(rst), .bus(b));
    pipe_ctrl #(.CNT_W(3), .PERF_W(4))  dut_s (.clk(clk), .rst(rst), .bus(s));

    int checks = 0;
    int errs   = 0;

    // minimal pc_reg fed by the DUT stall/flush outputs
    logic [31:0] pc;
    always @(posedge clk) begin
        if (rst)              pc <= 32'h0;
        else if (b.flush)     pc <= b.new_pc;
        else if (!b.stall[0]) pc <= pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        b.stallreq_id = 0; b.stallreq_ex = 0; b.mc_start = 0;
        b.mc_cycles = '0; b.flush_req = 0; b.flush_pc = '0;
    endtask

    initial begin
        idle_in();
        s.stallreq_id = 0; s.stallreq_ex = 0; s.mc_start = 0;
        s.mc_cycles = '0; s.flush_req = 0; s.flush_pc = '0;

        // reset with noisy inputs
        b.stallreq_ex = 1; b.flush_req = 1; b.flush_pc = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("rst_stall", 32'(b.stall), 32'h0);
            chk("rst_flush", 32'(b.flush), 32'h0);
            chk("rst_newpc", b.new_pc, 32'h0);
            chk("rst_busy",  32'(b.mc_busy), 32'h0);
            cyc();
        end
        rst = 0;
        idle_in();
        mid(); chk("rst_cnt", b.stall_cnt, 32'd0); chk("pc0", pc, 32'h0); cyc();
        mid(); chk("pc4", pc, 32'h4); cyc();
        mid(); chk("pc8", pc, 32'h8); cyc();

        // N=2
        b.mc_start = 1; b.mc_cycles = 3'd2;
        mid(); chk("n2_c1_stall", 32'(b.stall), 32'(STALL_EX)); chk("n2_c1_last", 32'(b.mc_last), 32'h0);
        cyc(); b.mc_start = 0; b.mc_cycles = 3'd0;
        mid(); chk("n2_c2_stall", 32'(b.stall), 32'h0); chk("n2_c2_last", 32'(b.mc_last), 32'h1);
        chk("n2_c2_busy", 32'(b.mc_busy), 32'h1);
        cyc();
        mid(); chk("n2_after_busy", 32'(b.mc_busy), 32'h0); chk("n2_cnt", b.stall_cnt, 32'd1);
        cyc();

        // N=5, with a stray mc_start mid-op that must be ignored
        b.mc_start = 1; b.mc_cycles = 3'd5;
        mid(); chk("n5_c1_stall", 32'(b.stall), 32'(STALL_EX)); chk("n5_c1_busy", 32'(b.mc_busy), 32'h0);
        cyc(); b.mc_start = 0; b.mc_cycles = 3'd0;
        for (int c = 2; c <= 4; c++) begin
            if (c == 3) begin b.mc_start = 1; b.mc_cycles = 3'd2; end
            mid();
            chk("n5_mid_stall", 32'(b.stall), 32'(STALL_EX));
            chk("n5_mid_busy",  32'(b.mc_busy), 32'h1);
            chk("n5_mid_last",  32'(b.mc_last), 32'h0);
            cyc(); b.mc_start = 0; b.mc_cycles = 3'd0;
        end
        mid(); chk("n5_c5_stall", 32'(b.stall), 32'h0); chk("n5_c5_last", 32'(b.mc_last), 32'h1);
        chk("n5_c5_busy", 32'(b.mc_busy), 32'h1);
        cyc();
        mid(); chk("n5_after_busy", 32'(b.mc_busy), 32'h0); chk("n5_cnt", b.stall_cnt, 32'd5);
        cyc();

        // degenerate lengths
        for (int n = 1; n >= 0; n--) begin
            b.mc_start = 1; b.mc_cycles = 3'(n);
            mid(); chk("deg_stall", 32'(b.stall), 32'h0); chk("deg_last", 32'(b.mc_last), 32'h1);
            chk("deg_busy", 32'(b.mc_busy), 32'h0);
            cyc(); idle_in();
            mid(); chk("deg_after_busy", 32'(b.mc_busy), 32'h0); chk("deg_after_last", 32'(b.mc_last), 32'h0);
            cyc();
        end
        mid(); chk("deg_cnt", b.stall_cnt, 32'd5); cyc();

        // priority
        b.stallreq_id = 1; b.stallreq_ex = 1;
        mid(); chk("pri_ex_id", 32'(b.stall), 32'(STALL_EX)); chk("pri_noflush_pc", b.new_pc, 32'h0); cyc();
        b.stallreq_ex = 0;
        mid(); chk("pri_id", 32'(b.stall), 32'(STALL_ID)); cyc();
        b.stallreq_ex = 1; b.flush_req = 1; b.flush_pc = 32'h20;
        mid(); chk("pri_fl_stall", 32'(b.stall), 32'h0); chk("pri_fl_flush", 32'(b.flush), 32'h1);
        chk("pri_fl_newpc", b.new_pc, 32'h20);
        cyc(); idle_in();
        mid(); chk("redirect_pc", pc, 32'h20); chk("pri_cnt", b.stall_cnt, 32'd7); cyc();

        // stallreq_id honoured on the mc_last cycle
        b.mc_start = 1; b.mc_cycles = 3'd2;
        mid(); cyc(); idle_in(); b.stallreq_id = 1;
        mid(); chk("last_id_stall", 32'(b.stall), 32'(STALL_ID)); chk("last_id_last", 32'(b.mc_last), 32'h1);
        cyc(); idle_in();
        mid(); chk("last_id_cnt", b.stall_cnt, 32'd9); cyc();

        // abort N=6 on its third cycle, restart right after
        b.mc_start = 1; b.mc_cycles = 3'd6;
        mid(); cyc(); idle_in();
        mid(); chk("ab_c2_stall", 32'(b.stall), 32'(STALL_EX)); cyc();
        b.flush_req = 1; b.flush_pc = 32'h40;
        mid(); chk("ab_stall", 32'(b.stall), 32'h0); chk("ab_flush", 32'(b.flush), 32'h1);
        chk("ab_newpc", b.new_pc, 32'h40); chk("ab_last", 32'(b.mc_last), 32'h0);
        cyc(); idle_in(); b.mc_start = 1; b.mc_cycles = 3'd2;
        mid(); chk("ab_next_busy", 32'(b.mc_busy), 32'h0); chk("ab_next_last", 32'(b.mc_last), 32'h0);
        chk("ab_restart_stall", 32'(b.stall), 32'(STALL_EX));
        cyc(); idle_in();
        mid(); chk("ab_restart_last", 32'(b.mc_last), 32'h1); chk("ab_restart_busy", 32'(b.mc_busy), 32'h1);
        cyc();
        mid(); chk("ab_cnt", b.stall_cnt, 32'd12); cyc();

        // reset while in MULTI
        b.mc_start = 1; b.mc_cycles = 3'd5;
        mid(); cyc(); idle_in(); mid(); cyc();
        rst = 1; b.stallreq_ex = 1;
        mid(); chk("rm_stall", 32'(b.stall), 32'h0); chk("rm_busy", 32'(b.mc_busy), 32'h0);
        chk("rm_last", 32'(b.mc_last), 32'h0);
        cyc(); rst = 0; idle_in();
        mid(); chk("rm_after_busy", 32'(b.mc_busy), 32'h0); chk("rm_after_last", 32'(b.mc_last), 32'h0);
        chk("rm_after_stall", 32'(b.stall), 32'h0); chk("rm_cnt", b.stall_cnt, 32'd0);
        cyc();

        // saturation on the 4-bit counter build
        s.stallreq_id = 1;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (i == 14) chk("sat_14", 32'(s.stall_cnt), 32'hE);
            if (i == 15) chk("sat_15", 32'(s.stall_cnt), 32'hF);
            cyc();
        end
        s.stallreq_id = 0;
        mid(); chk("sat_hold", 32'(s.stall_cnt), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the OpenMIPS five-stage core.
- Merges stall requests from ID and EX and owns the cycle counter for multi-cycle EX operations (madd/msub, future div).
- Drives the 6-bit stall vector consumed by pc_reg and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Issues a flush pulse with a redirect PC on exceptions, and keeps a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 3: width of the multi-cycle length and counter; max op length 2^CNT_W-1 = 7 cycles.
- PERF_W, 32: width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stallreq_id  in  1  ID requests stall (load-use hazard).
- stallreq_ex  in  1  EX requests stall (generic).
- mc_start  in  1  EX begins a multi-cycle op this cycle.
- mc_cycles  in  CNT_W  total EX occupancy N of that op; sampled only with mc_start.
- flush_req  in  1  exception/redirect request.
- flush_pc  in  32  redirect target.
- stall  out  6  [0]=PC hold, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1 = stop.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  PC to load when flush=1.
- mc_busy  out  1  multi-cycle op in progress (state MULTI).
- mc_last  out  1  current cycle is the final EX cycle of the multi-cycle op.
- stall_cnt  out  PERF_W  cycles in which stall[0]=1, saturating.

Behaviour:
- Reset, rst=1 at posedge: state<=IDLE, cnt<=0, n_lat<=0, stall_cnt<=0.
- While rst=1: stall=0, flush=0, new_pc=0, mc_busy=0, mc_last=0; all inputs ignored.
- States: IDLE, MULTI. cnt and n_lat are CNT_W registers.
- Stall codes (combinational from state and inputs, same-cycle effect):
  - STALL_NONE = 000000
  - STALL_ID = 000111
  - STALL_EX = 001111
- Priority: flush_req > (mc stall | stallreq_ex) > stallreq_id.
- Flush: flush_req=1 gives flush=1, new_pc=flush_pc, stall=000000 in the same cycle.
  - Next state IDLE, cnt<=0; an in-flight multi-cycle op is aborted, so mc_last is never asserted for it.
  - When flush=0, new_pc=0.
- IDLE:
  - mc_start=1 with mc_cycles N>=2: stall=STALL_EX this cycle, n_lat<=N, cnt<=1, next state MULTI.
  - mc_start=1 with N in {0,1}: no stall, mc_last=1 this cycle, stay IDLE.
- MULTI: mc_busy=1.
  - cnt==n_lat-1: mc_last=1, mc-stall released (stall falls back to stallreq_ex/id), next state IDLE, cnt<=0.
  - Otherwise: stall=STALL_EX, cnt<=cnt+1.
- An N-cycle op therefore stalls exactly N-1 cycles (start cycle included) and EX advances on cycle N.
- mc_start while in MULTI is ignored; mc_cycles is not resampled.
- stallreq_ex or stallreq_id on mc_last cycle: that request is still honoured, STALL_EX or STALL_ID respectively.
- stall_cnt increments at posedge when stall[0]=1 and rst=0; holds at all-ones on saturation.
- Reset mid-MULTI: returns to IDLE next edge with no mc_last pulse.

Decomposition:
- defines.v additions:
  - StallNone, StallId, StallEx 6-bit codes.
  - CtrlIdle, CtrlMulti state codes.
  - Reuse existing RstEnable, Stop/NoStop and InstAddrBus.
- One natural sub-module: sat_counter (PERF_W, inc, clk, rst), reusable for other perf counters. The FSM/counter stays inline.

Test Plan:
- Reset: hold rst=1 3 cycles with stallreq_ex=1, flush_req=1 -> stall=000000, flush=0, new_pc=0, stall_cnt=0; after release, pc_reg PC sequence 0,4,8 resumes.
- Multi-cycle: mc_start=1, mc_cycles=2 in IDLE -> stall=001111 for 1 cycle, mc_last=1 on cycle 2, stall=0 on cycle 2; repeat N=5 -> 4 stall cycles, mc_busy high cycles 2-5, stall_cnt +4.
- Degenerate: mc_start with N=1 and N=0 -> no stall, mc_last=1 same cycle, state stays IDLE.
- Priority: stallreq_id=1 and stallreq_ex=1 together -> 001111; stallreq_id alone -> 000111; flush_req=1 with both set and flush_pc=32'h00000020 -> stall=0, flush=1, new_pc=32'h00000020.
- Abort: mc_start N=6, flush_req on 3rd cycle -> flush=1, stall=0, next cycle mc_busy=0, mc_last never asserted; new mc_start accepted the following cycle.
- Saturation: preload stall_cnt near max (PERF_W=4 build), hold stallreq_id 20 cycles -> stall_cnt stops at 4'hF.
